speaker_arbiter: RTL and testbench

- Schedules and shares the board speaker between two sound sources: a continuous music tone and a one-shot sound effect (SFX).
- Generates square-wave 16-bit two's-complement samples and drives audio_left/audio_right into the I2S speaker serializer.
- SFX has priority: it preempts music, plays for a fixed cycle count, then inserts a silence gap before the speaker is released.

---
 rtl/speaker_arbiter.sv | 131 +++++++++++++
 tb/tb_speaker_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/speaker_arbiter.sv
// speaker_arbiter: shares the speaker between a music tone and a one-shot SFX; optional SPEAKER_MIX_EN mixes music under SFX
module speaker_arbiter #(
    parameter int          NOTE_W     = 20,
    parameter int          DUR_W      = 24,
    parameter logic [15:0] AMPLITUDE  = 16'h2000,
    parameter int          GAP_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              music_req,
    input  logic [NOTE_W-1:0] music_half_period,
    output logic              music_gnt,
    input  logic              sfx_req,
    input  logic [NOTE_W-1:0] sfx_half_period,
    input  logic [DUR_W-1:0]  sfx_duration,
    output logic              sfx_ack,
    output logic              sfx_done,
    input  logic              mute,
    output logic [15:0]       audio_left,
    output logic [15:0]       audio_right,
    output logic              busy,
    output logic [1:0]        state
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [15:0] NEG = ~AMPLITUDE + 16'd1;
    typedef enum logic [1:0] {IDLE, MUSIC, SFX, GAP} state_t;
    state_t st, nx;
    logic phase, music_ok, enter_sfx, enter_music, tone_run, gnt_next;
    logic [NOTE_W-1:0] cnt, period;
    logic [DUR_W-1:0] dur;
    logic [GW-1:0] gap;
    logic [15:0] sample;
    function automatic logic [15:0] tone(input logic p);
        return p ? AMPLITUDE : NEG;
    endfunction
    assign music_ok    = music_req && music_half_period != '0;
    assign enter_sfx   = nx == SFX && st != SFX;
    assign enter_music = nx == MUSIC && st != MUSIC;
    assign tone_run    = st == MUSIC || st == SFX;
    assign state       = st;
    // next-state: SFX wins from IDLE/MUSIC, SFX and GAP run to their counts
    always_comb begin
        nx = st;
        if (st == IDLE || st == MUSIC)
            nx = sfx_req ? SFX : (music_ok ? MUSIC : IDLE);
        else
            nx = st == SFX ? (dur == DUR_W'(1) ? GAP : SFX) : (gap == GW'(1) ? IDLE : GAP);
    end
`ifdef SPEAKER_MIX_EN
    logic m_phase, m_run, m_next;
    logic [NOTE_W-1:0] m_cnt, m_period;
    logic [15:0] m_smp, s_smp;
    assign m_next   = music_ok && (nx == MUSIC || (m_run && nx != IDLE));
    assign m_smp    = (m_run && m_period != '0) ? tone(m_phase) : '0;
    assign s_smp    = (st == SFX && period != '0) ? tone(phase) : '0;
    assign sample   = (mute || st == IDLE) ? '0 : st == SFX ? ($signed(m_smp) >>> 1) + ($signed(s_smp) >>> 1) : m_smp;
    assign gnt_next = m_next;
    // dedicated music tone generator that keeps running underneath SFX and GAP
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_run    <= 1'b0;
            m_phase  <= 1'b0;
            m_cnt    <= '0;
            m_period <= '0;
        end else begin
            m_run <= m_next;
            if (m_next && !m_run) begin
                m_phase  <= 1'b1;
                m_cnt    <= '0;
                m_period <= music_half_period;
            end else if (m_run) begin
                if (m_cnt == m_period - NOTE_W'(1)) begin
                    m_cnt    <= '0;
                    m_phase  <= ~m_phase;
                    m_period <= music_half_period;
                end else begin
                    m_cnt <= m_cnt + NOTE_W'(1);
                end
            end
        end
    end
`else
    assign sample   = (!mute && tone_run && period != '0) ? tone(phase) : '0;
    assign gnt_next = nx == MUSIC;
`endif
    // state, counters, shared tone generator and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= IDLE;
            phase       <= 1'b0;
            cnt         <= '0;
            period      <= '0;
            dur         <= '0;
            gap         <= '0;
            music_gnt   <= 1'b0;
            sfx_ack     <= 1'b0;
            sfx_done    <= 1'b0;
            busy        <= 1'b0;
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            st          <= nx;
            busy        <= nx != IDLE;
            music_gnt   <= gnt_next;
            sfx_ack     <= enter_sfx;
            sfx_done    <= st == SFX && nx == GAP;
            audio_left  <= sample;
            audio_right <= sample;
            gap         <= (nx == GAP && st != GAP) ? GW'(GAP_CYCLES) : (st == GAP ? gap - GW'(1) : gap);
            if (enter_sfx) begin
                phase  <= 1'b1;
                cnt    <= '0;
                period <= sfx_half_period;
                dur    <= sfx_duration == '0 ? DUR_W'(1) : sfx_duration;
            end else if (enter_music) begin
                phase  <= 1'b1;
                cnt    <= '0;
                period <= music_half_period;
            end else if (tone_run) begin
                if (cnt == period - NOTE_W'(1)) begin
                    cnt    <= '0;
                    phase  <= ~phase;
                    period <= st == MUSIC ? music_half_period : period;
                end else begin
                    cnt <= cnt + NOTE_W'(1);
                end
                dur <= st == SFX ? dur - DUR_W'(1) : dur;
            end
        end
    end
endmodule

// File: tb/tb_speaker_arbiter.sv
// tb_speaker_arbiter: directed checks of reset, music tone, preemption, edge values, mute and mid-SFX reset
module tb_speaker_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic music_req = 1'b0, sfx_req = 1'b0, mute = 1'b0;
    logic [19:0] music_half_period = '0, sfx_half_period = '0;
    logic [23:0] sfx_duration = '0;
    logic music_gnt, sfx_ack, sfx_done, busy;
    logic [15:0] audio_left, audio_right;
    logic [1:0] state;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    speaker_arbiter #(
        .NOTE_W(20), .DUR_W(24), .AMPLITUDE(16'h1000), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .music_req(music_req), .music_half_period(music_half_period), .music_gnt(music_gnt),
        .sfx_req(sfx_req), .sfx_half_period(sfx_half_period), .sfx_duration(sfx_duration),
        .sfx_ack(sfx_ack), .sfx_done(sfx_done), .mute(mute),
        .audio_left(audio_left), .audio_right(audio_right), .busy(busy), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic audio(input string tag, input logic [15:0] exp);
        check(tag, audio_left, exp);
        check({tag, "_r"}, audio_right, exp);
    endtask

    initial begin
        music_req = 1'b1; sfx_req = 1'b1; music_half_period = 20'd3;
        sfx_half_period = 20'd2; sfx_duration = 24'd10;
        tick(3);
        check("rst_state", state, 0);
        audio("rst_audio", 16'h0000);
        check("rst_gnt", music_gnt, 0);
        check("rst_ack", sfx_ack, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1; sfx_req = 1'b0;
        #1 check("rel_state", state, 0);
        tick();
        check("mus_state", state, 1);
        check("mus_gnt", music_gnt, 1);
        check("mus_busy", busy, 1);
        audio("mus_first", 16'h0000);
        for (int k = 0; k < 9; k++) begin
            tick();
            audio($sformatf("mus3_%0d", k), ((k / 3) % 2 == 0) ? 16'h1000 : 16'hF000);
        end
        music_half_period = 20'd5;
        for (int k = 0; k < 13; k++) begin
            tick();
            audio($sformatf("mus5_%0d", k), (k < 3 || k >= 8) ? 16'hF000 : 16'h1000);
        end
        mute = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            audio($sformatf("mute_%0d", k), 16'h0000);
        end
        check("mute_state", state, 1);
        mute = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            audio($sformatf("unmute_%0d", k), k < 3 ? 16'hF000 : 16'h1000);
        end
`ifndef SPEAKER_MIX_EN
        sfx_req = 1'b1; sfx_half_period = 20'd2; sfx_duration = 24'd10;
        tick();
        sfx_req = 1'b0;
        check("pre_state", state, 2);
        check("pre_ack", sfx_ack, 1);
        check("pre_gnt", music_gnt, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            audio($sformatf("sfx_%0d", k), ((k / 2) % 2 == 0) ? 16'h1000 : 16'hF000);
            if (k == 0) check("ack_pulse", sfx_ack, 0);
            if (k == 8) check("sfx_last_state", state, 2);
            if (k == 8) check("sfx_no_done", sfx_done, 0);
        end
        check("gap_state", state, 3);
        check("gap_done", sfx_done, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            audio($sformatf("gap_%0d", k), 16'h0000);
            check($sformatf("gap_st_%0d", k), state, 3);
        end
        check("done_pulse", sfx_done, 0);
        tick();
        check("post_idle", state, 0);
        audio("post_idle_audio", 16'h0000);
        tick();
        check("back_music", state, 1);
        check("back_gnt", music_gnt, 1);
        sfx_req = 1'b1; sfx_duration = 24'd0; music_half_period = 20'd0;
        tick();
        sfx_req = 1'b0;
        check("d0_state", state, 2);
        tick();
        check("d0_gap", state, 3);
        check("d0_done", sfx_done, 1);
        tick(4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("h0_idle_%0d", k), state, 0);
            check($sformatf("h0_gnt_%0d", k), music_gnt, 0);
            tick();
        end
        check("h0_busy", busy, 0);
        sfx_req = 1'b1; sfx_duration = 24'd10;
        tick();
        check("ms_ack", sfx_ack, 1);
        tick();
        check("ms_noreack", sfx_ack, 0);
        check("ms_hold", state, 2);
        sfx_req = 1'b0;
        tick(4);
        check("ms_sfx5", state, 2);
        rst = 1'b0;
        tick();
        check("ms_idle", state, 0);
        check("ms_done", sfx_done, 0);
        audio("ms_audio", 16'h0000);
        rst = 1'b1;
        tick();
        check("ms_after", state, 0);
        check("ms_after_done", sfx_done, 0);
`else
        rst = 1'b0;
        tick();
        rst = 1'b1; music_half_period = 20'd4;
        tick(3);
        check("mix_music", state, 1);
        sfx_req = 1'b1; sfx_half_period = 20'd2; sfx_duration = 24'd8;
        tick();
        sfx_req = 1'b0;
        check("mix_sfx", state, 2);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("mix_set_%0d", k),
                  (audio_left == 16'h1000 || audio_left == 16'h0000 || audio_left == 16'hF000), 1);
            check($sformatf("mix_gnt_%0d", k), music_gnt, 1);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
